// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared widths, handshake encodings and March C- element table.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int W      = 8;
  localparam int ADDR_W = 4;

  localparam logic WRD_WRITE = 1'b1;
  localparam logic WRD_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    M4   = 3'd5,
    M5   = 3'd6,
    DONE = 3'd7
  } march_state_t;

  // Per-element behaviour; *_inv selects ~BG instead of BG.
  typedef struct packed {
    logic desc;
    logic has_read;
    logic exp_inv;
    logic has_write;
    logic wr_inv;
  } elem_info_t;

  function automatic logic elem_is_desc(input march_state_t s);
    return (s == M3) || (s == M4) || (s == M5);
  endfunction

  function automatic elem_info_t elem_info(input march_state_t s);
    elem_info_t e;
    e      = '0;
    e.desc = elem_is_desc(s);
    case (s)
      M0: e.has_write = 1'b1;
      M1: begin e.has_read = 1'b1; e.has_write = 1'b1; e.wr_inv = 1'b1; end
      M2: begin e.has_read = 1'b1; e.exp_inv = 1'b1; e.has_write = 1'b1; end
      M3: begin e.has_read = 1'b1; e.has_write = 1'b1; e.wr_inv = 1'b1; end
      M4: begin e.has_read = 1'b1; e.exp_inv = 1'b1; e.has_write = 1'b1; end
      M5: e.has_read = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic march_state_t next_elem(input march_state_t s);
    case (s)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return DONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_addr_gen
// Brief    : Up/down address counter with directional load and last-address flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_load_desc,
  input  logic              i_step,
  input  logic              i_desc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_is_last
);

  localparam logic [ADDR_W-1:0] c_TOP = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_desc ? c_TOP : '0;
    end else if (i_step) begin
      r_addr <= i_desc ? (r_addr - c_ONE) : (r_addr + c_ONE);
    end
  end

  // End of element is an explicit compare so wrap-around never terminates a pass.
  assign o_addr    = r_addr;
  assign o_is_last = i_desc ? (r_addr == '0) : (r_addr == c_TOP);

endmodule
`default_nettype wire

// File: rtl/mem_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : mem_march_bist
// Brief    : March C- BIST initiator for a single-port valid/ready RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_march_bist #(
  parameter int              W        = mem_pkg::W,
  parameter int              ADDR_W   = mem_pkg::ADDR_W,
  parameter logic [W-1:0]    BG       = W'(8'h55),
  parameter int              MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [W-1:0]      fail_exp,
  output logic [W-1:0]      fail_got,
  output logic              valid,
  output logic              wrd,
  output logic [ADDR_W-1:0] addr,
  output logic [W-1:0]      wdata,
  input  logic              ready,
  input  logic [W-1:0]      rdata
);

  import mem_pkg::*;

  localparam int                 c_WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(MAX_WAIT - 1);

  march_state_t         r_state;
  logic                 r_armed;
  logic [c_WAIT_W-1:0]  r_wait_cnt;
  logic                 r_valid;
  logic                 r_wrd;
  logic [W-1:0]         r_wdata;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;
  logic [ADDR_W-1:0]    r_fail_addr;
  logic [W-1:0]         r_fail_exp;
  logic [W-1:0]         r_fail_got;

  elem_info_t           w_info;
  march_state_t         w_next_elem;
  logic [W-1:0]         w_exp;
  logic [W-1:0]         w_wr_pat;
  logic                 w_hs;
  logic                 w_accept;
  logic                 w_miscmp;
  logic                 w_op_end;
  logic                 w_step;
  logic                 w_load;
  logic                 w_load_desc;
  logic                 w_stall_abort;
  logic                 w_is_last;
  logic [ADDR_W-1:0]    w_addr;

  always_comb begin
    w_info        = elem_info(r_state);
    w_next_elem   = next_elem(r_state);
    w_exp         = w_info.exp_inv ? ~BG : BG;
    w_wr_pat      = w_info.wr_inv  ? ~BG : BG;
    w_hs          = r_valid && ready;
    w_accept      = start && r_armed && ((r_state == IDLE) || (r_state == DONE));
    w_miscmp      = w_hs && (r_wrd == WRD_READ) && (rdata != w_exp);
    // An address is finished after its write, or after its read in read-only elements.
    w_op_end      = w_hs && !w_miscmp && ((r_wrd == WRD_WRITE) || !w_info.has_write);
    w_step        = w_op_end && !w_is_last;
    w_load        = w_accept || (w_op_end && w_is_last && (r_state != M5));
    w_load_desc   = w_accept ? 1'b0 : elem_is_desc(w_next_elem);
    w_stall_abort = r_valid && !ready && (r_wait_cnt == c_WAIT_LIM);
  end

  mem_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_desc (w_load_desc),
    .i_step      (w_step),
    .i_desc      (w_info.desc),
    .o_addr      (w_addr),
    .o_is_last   (w_is_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_wait_cnt  <= '0;
      r_valid     <= 1'b0;
      r_wrd       <= WRD_READ;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else begin
      // Blocks a start that coincides with the first edge after reset release.
      r_armed <= 1'b1;

      if (w_hs) begin
        r_wait_cnt <= '0;
      end else if (r_valid && !ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state     <= M0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
            r_wait_cnt  <= '0;
            r_valid     <= 1'b1;
            r_wrd       <= WRD_WRITE;
            r_wdata     <= BG;
          end
        end

        default: begin
          if (w_miscmp) begin
            r_fail_addr <= w_addr;
            r_fail_exp  <= w_exp;
            r_fail_got  <= rdata;
            r_state     <= DONE;
            r_valid     <= 1'b0;
            r_wrd       <= WRD_READ;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_stall_abort) begin
            r_fail_addr <= w_addr;
            r_timeout   <= 1'b1;
            r_state     <= DONE;
            r_valid     <= 1'b0;
            r_wrd       <= WRD_READ;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_hs) begin
            if ((r_wrd == WRD_READ) && w_info.has_write) begin
              r_wrd   <= WRD_WRITE;
              r_wdata <= w_wr_pat;
            end else if (!w_is_last) begin
              r_wrd   <= w_info.has_read ? WRD_READ : WRD_WRITE;
              r_wdata <= w_info.has_read ? '0 : w_wr_pat;
            end else if (r_state == M5) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_wrd   <= WRD_READ;
              r_wdata <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= w_next_elem;
              r_wrd   <= WRD_READ;
              r_wdata <= '0;
            end
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign fail_addr = r_fail_addr;
  assign fail_exp  = r_fail_exp;
  assign fail_got  = r_fail_got;
  assign valid     = r_valid;
  assign wrd       = r_wrd;
  assign addr      = w_addr;
  assign wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_march_bist
// Brief    : Scoreboard bench: RAM responder model checks every request in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_march_bist;

  localparam int         c_W     = 8;
  localparam int         c_AW    = 4;
  localparam int         c_DEPTH = 16;
  localparam logic [7:0] c_P     = 8'h55;
  localparam logic [7:0] c_NP    = 8'hAA;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            ready = 1'b0;
  logic [c_W-1:0]  rdata = '0;
  logic            busy, done, pass, timeout, valid, wrd;
  logic [c_AW-1:0] fail_addr, addr;
  logic [c_W-1:0]  fail_exp, fail_got, wdata;

  always #5 clk = ~clk;

  mem_march_bist #(.W(c_W), .ADDR_W(c_AW), .BG(c_P), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .valid(valid), .wrd(wrd), .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata)
  );

  typedef struct packed {
    logic            wrd;
    logic [c_AW-1:0] addr;
    logic [c_W-1:0]  wdata;
  } xfer_t;

  xfer_t          exp_q[$];
  logic [c_W-1:0] mem [c_DEPTH];
  int n_checks = 0;
  int n_errors = 0;
  int lat = 0;
  int kill_after = 1000000;
  int hs_count = 0;
  int stall_total = 0;
  bit stuck_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic w, input int a, input logic [7:0] d);
    xfer_t x;
    x.wrd = w; x.addr = c_AW'(a); x.wdata = d;
    exp_q.push_back(x);
  endtask

  // Expected March C- request stream, written out element by element.
  task automatic push_march();
    exp_q.delete();
    for (int a = 0; a < c_DEPTH; a++) push(1'b1, a, c_P);
    for (int a = 0; a < c_DEPTH; a++) begin push(1'b0, a, 8'h00); push(1'b1, a, c_NP); end
    for (int a = 0; a < c_DEPTH; a++) begin push(1'b0, a, 8'h00); push(1'b1, a, c_P); end
    for (int a = c_DEPTH-1; a >= 0; a--) begin push(1'b0, a, 8'h00); push(1'b1, a, c_NP); end
    for (int a = c_DEPTH-1; a >= 0; a--) begin push(1'b0, a, 8'h00); push(1'b1, a, c_P); end
    for (int a = c_DEPTH-1; a >= 0; a--) push(1'b0, a, 8'h00);
  endtask

  // RAM responder and monitor: every presented request must match the queue head.
  initial begin : responder
    int    wcnt;
    xfer_t cur;
    logic  rdy;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst || !valid) begin
        ready = 1'b0;
        wcnt  = 0;
      end else begin
        cur = {wrd, addr, wdata};
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL xfer_extra actual=%0h required=none", cur);
        end else begin
          check("xfer", 32'(cur), 32'(exp_q[0]));
        end
        rdy   = (wcnt >= lat) && (hs_count < kill_after);
        ready = rdy;
        if (rdy) begin
          if (wrd) begin
            mem[addr] = wdata;
            rdata = '0;
          end else begin
            rdata = mem[addr] | ((stuck_en && addr == 4'h9) ? 8'h08 : 8'h00);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_count++;
          wcnt = 0;
        end else begin
          wcnt++;
          stall_total++;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while (!done && cyc < bound) begin @(negedge clk); cyc++; end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL wait_done actual=not_done required=done_within_%0d", bound);
    end
  endtask

  task automatic wait_hs(input int n);
    int c;
    c = 0;
    while (hs_count < n && c < 2000) begin @(negedge clk); c++; end
    if (hs_count < n) begin
      n_checks++; n_errors++;
      $display("FAIL wait_hs actual=%0d required=%0d", hs_count, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, valid, 0);     check({tag, "_wrd"}, wrd, 0);
    check({tag, "_busy"}, busy, 0);       check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);       check({tag, "_timeout"}, timeout, 0);
    check({tag, "_addr"}, addr, 0);       check({tag, "_wdata"}, wdata, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_fail_exp"}, fail_exp, 0);
    check({tag, "_fail_got"}, fail_got, 0);
  endtask

  initial begin : main
    int cyc;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);

    // Good RAM, zero latency
    push_march(); hs_count = 0;
    pulse_start();
    check("run1_busy", busy, 1);
    wait_done(400, cyc);
    check("run1_cycles", cyc, 160);
    check("run1_pass", pass, 1);
    check("run1_timeout", timeout, 0);
    check("run1_busy_end", busy, 0);
    check("run1_hs", hs_count, 160);
    check("run1_q_left", exp_q.size(), 0);
    for (int a = 0; a < c_DEPTH; a++) check("run1_mem", mem[a], 32'h55);

    // Two waiting cycles on every access
    lat = 2; push_march(); hs_count = 0;
    pulse_start();
    wait_done(1000, cyc);
    check("lat2_cycles", cyc, 480);
    check("lat2_pass", pass, 1);
    check("lat2_timeout", timeout, 0);
    check("lat2_q_left", exp_q.size(), 0);
    lat = 0;

    // Bit 3 stuck-at-1 at address 9
    stuck_en = 1'b1; push_march(); hs_count = 0;
    pulse_start();
    wait_done(400, cyc);
    check("stuck_cycles", cyc, 35);
    check("stuck_pass", pass, 0);
    check("stuck_timeout", timeout, 0);
    check("stuck_fail_addr", fail_addr, 9);
    check("stuck_fail_exp", fail_exp, 32'h55);
    check("stuck_fail_got", fail_got, 32'h5D);
    check("stuck_valid", valid, 0);
    check("stuck_hs", hs_count, 35);
    @(negedge clk);
    check("stuck_valid_hold", valid, 0);
    stuck_en = 1'b0; exp_q.delete();

    // Ready stuck low after 19 handshakes: pending request is M1 write at addr 1
    kill_after = 19; stall_total = 0; push_march(); hs_count = 0;
    pulse_start();
    wait_done(400, cyc);
    check("to_cycles", cyc, 35);
    check("to_timeout", timeout, 1);
    check("to_pass", pass, 0);
    check("to_fail_addr", fail_addr, 1);
    check("to_valid", valid, 0);
    check("to_stalls", stall_total, 16);
    kill_after = 1000000; exp_q.delete();

    // Reset in the middle of M2, start held across reset release, then rerun
    push_march(); hs_count = 0;
    pulse_start();
    wait_hs(55);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    start = 1'b1; rst = 1'b1;
    @(negedge clk); start = 1'b0;
    check("release_start_busy", busy, 0);
    check("release_start_valid", valid, 0);
    push_march(); hs_count = 0;
    pulse_start();
    wait_done(400, cyc);
    check("rerun_cycles", cyc, 160);
    check("rerun_pass", pass, 1);

    // start during busy ignored; start in DONE restarts from M0 addr 0
    push_march(); hs_count = 0;
    pulse_start();
    wait_hs(30);
    pulse_start();
    wait_done(400, cyc);
    check("midstart_pass", pass, 1);
    check("midstart_hs", hs_count, 160);
    check("midstart_q_left", exp_q.size(), 0);
    push_march(); hs_count = 0;
    pulse_start();
    check("restart_done", done, 0);
    check("restart_pass", pass, 0);
    check("restart_busy", busy, 1);
    check("restart_valid", valid, 1);
    check("restart_addr", addr, 0);
    check("restart_wrd", wrd, 1);
    check("restart_wdata", wdata, 32'h55);
    wait_done(400, cyc);
    check("restart_cycles", cyc, 160);
    check("restart_end_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
